// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared states, default widths and sign-extension helper for the FIR stream driver
package fir_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_LOAD    = 3'd4
    } state_t;

    localparam int TAP_SIZE_DEF    = 3;
    localparam int NBR_OF_TAPS_DEF = 6;
    localparam int X_N_SIZE_DEF    = 8;

    // Treats the low w bits of v as signed and extends them across all 32 bits.
    function automatic logic [31:0] sext32(input logic [31:0] v, input int w);
        logic [31:0] m;
        logic        sign;
        m    = 32'hFFFF_FFFF << w;
        sign = |(v & (32'd1 << (w - 1)));
        return sign ? (v | m) : (v & ~m);
    endfunction

endpackage

// File: rtl/fir_coeff_serializer.sv
// rtl/fir_coeff_serializer.sv - holds a captured coefficient set and presents the next load-cycle value
module fir_coeff_serializer
    import fir_pkg::*;
#(
    parameter int TAP_SIZE    = TAP_SIZE_DEF,
    parameter int NBR_OF_TAPS = NBR_OF_TAPS_DEF,
    parameter int X_N_SIZE    = X_N_SIZE_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_capture,
    input  logic                            i_step,
    input  logic [NBR_OF_TAPS*TAP_SIZE-1:0] i_coeffs,
    output logic [X_N_SIZE-1:0]             o_x_n_next,
    output logic                            o_set_next,
    output logic                            o_last
);

    localparam int J_W = $clog2(NBR_OF_TAPS + 1);

    logic [NBR_OF_TAPS*TAP_SIZE-1:0] r_coeffs;
    logic [J_W-1:0]                  r_j;
    logic [J_W-1:0]                  w_idx;
    logic [TAP_SIZE-1:0]             w_tap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coeffs <= '0;
            r_j      <= '0;
        end else if (i_capture) begin
            r_coeffs <= i_coeffs;
            r_j      <= '0;
        end else if (i_step) begin
            r_j <= r_j + 1'b1;
        end
    end

    // Outputs describe index j+1 (or j=0 on capture) so the top can register them.
    always_comb begin
        w_idx = J_W'(NBR_OF_TAPS - 1) - r_j;
        w_tap = '0;
        if (i_capture) begin
            w_tap = i_coeffs[(NBR_OF_TAPS-1)*TAP_SIZE +: TAP_SIZE];
        end else if (r_j < J_W'(NBR_OF_TAPS)) begin
            w_tap = TAP_SIZE'(r_coeffs >> (w_idx * TAP_SIZE));
        end
    end

    assign o_x_n_next = X_N_SIZE'(sext32(32'(w_tap), TAP_SIZE));
    assign o_set_next = i_capture || (r_j != J_W'(NBR_OF_TAPS - 1));
    assign o_last     = (r_j == J_W'(NBR_OF_TAPS));

endmodule

// File: rtl/fir_stream_driver.sv
// rtl/fir_stream_driver.sv - sequences coefficient loads and held sample periods onto the serial FIR inputs
module fir_stream_driver
    import fir_pkg::*;
#(
    parameter int TAP_SIZE       = TAP_SIZE_DEF,
    parameter int NBR_OF_TAPS    = NBR_OF_TAPS_DEF,
    parameter int X_N_SIZE       = X_N_SIZE_DEF,
    parameter int SAMPLE_PERIOD  = 8,
    parameter int STARTUP_CYCLES = 4,
    parameter int DRAIN_CYCLES   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stream_en,
    input  logic [X_N_SIZE-1:0]             s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NBR_OF_TAPS*TAP_SIZE-1:0] cfg_coeffs,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    output logic [X_N_SIZE-1:0]             x_n,
    output logic                            s_axis_fir_tvalid,
    output logic                            s_set_coeffs,
    output logic                            busy,
    output logic                            underrun
);

    localparam int CNT_W = 16;

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [X_N_SIZE-1:0] r_x_n, w_x_nx;
    logic                r_tvalid, w_tvalid_nx;
    logic                r_set, w_set_nx;
    logic                r_s_ready, w_s_ready_nx;
    logic                r_cfg_ready, w_cfg_ready_nx;
    logic                r_busy;
    logic                r_underrun, w_underrun_nx;

    logic [X_N_SIZE-1:0] w_ser_x;
    logic                w_ser_set, w_ser_last;
    logic                w_capture, w_step, w_period_start;

    fir_coeff_serializer #(
        .TAP_SIZE    (TAP_SIZE),
        .NBR_OF_TAPS (NBR_OF_TAPS),
        .X_N_SIZE    (X_N_SIZE)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .i_capture  (w_capture),
        .i_step     (w_step),
        .i_coeffs   (cfg_coeffs),
        .o_x_n_next (w_ser_x),
        .o_set_next (w_ser_set),
        .o_last     (w_ser_last)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt + 1'b1;
        w_x_nx         = '0;
        w_tvalid_nx    = 1'b0;
        w_set_nx       = 1'b0;
        w_s_ready_nx   = 1'b0;
        w_cfg_ready_nx = 1'b0;
        w_underrun_nx  = 1'b0;
        w_capture      = 1'b0;
        w_step         = 1'b0;
        w_period_start = 1'b0;

        case (r_state)
            ST_STARTUP: begin
                if (r_cnt == CNT_W'(STARTUP_CYCLES - 1)) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end
            end
            ST_IDLE: begin
                w_cnt_nx = '0;
                if (cfg_valid) begin
                    w_state_nx = ST_LOAD;
                    w_capture  = 1'b1;
                end else if (stream_en) begin
                    w_state_nx     = ST_STREAM;
                    w_period_start = 1'b1;
                end
            end
            ST_STREAM: begin
                w_tvalid_nx = 1'b1;
                w_x_nx      = r_x_n;
                // Only a completed period may hand over to drain or idle.
                if (r_cnt == CNT_W'(SAMPLE_PERIOD - 1)) begin
                    w_cnt_nx    = '0;
                    w_tvalid_nx = 1'b0;
                    w_x_nx      = '0;
                    if (cfg_valid) begin
                        w_state_nx = ST_DRAIN;
                    end else if (!stream_en) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_period_start = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_LOAD;
                    w_capture  = 1'b1;
                end
            end
            ST_LOAD: begin
                w_cnt_nx = '0;
                if (w_ser_last) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_step   = 1'b1;
                    w_x_nx   = w_ser_x;
                    w_set_nx = w_ser_set;
                end
            end
            default: begin
                w_state_nx = ST_STARTUP;
            end
        endcase

        if (w_capture) begin
            w_cfg_ready_nx = 1'b1;
            w_x_nx         = w_ser_x;
            w_set_nx       = w_ser_set;
        end

        if (w_period_start) begin
            w_cnt_nx    = '0;
            w_tvalid_nx = 1'b1;
            if (s_valid) begin
                w_s_ready_nx = 1'b1;
                w_x_nx       = s_data;
            end else begin
                w_underrun_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_STARTUP;
            r_cnt       <= '0;
            r_x_n       <= '0;
            r_tvalid    <= 1'b0;
            r_set       <= 1'b0;
            r_s_ready   <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_x_n       <= w_x_nx;
            r_tvalid    <= w_tvalid_nx;
            r_set       <= w_set_nx;
            r_s_ready   <= w_s_ready_nx;
            r_cfg_ready <= w_cfg_ready_nx;
            r_busy      <= (w_state_nx != ST_IDLE);
            r_underrun  <= w_underrun_nx;
        end
    end

    assign x_n               = r_x_n;
    assign s_axis_fir_tvalid = r_tvalid;
    assign s_set_coeffs      = r_set;
    assign s_ready           = r_s_ready;
    assign cfg_ready         = r_cfg_ready;
    assign busy              = r_busy;
    assign underrun          = r_underrun;

endmodule

// File: tb/tb_fir_stream_driver.sv
// tb/tb_fir_stream_driver.sv - directed phase schedule with per-cycle expected outputs and a tap-shift filter model
module tb_fir_stream_driver;

    localparam int P  = 8;
    localparam int N  = 6;
    localparam int D  = 8;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stream_en = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [17:0] cfg_coeffs = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  x_n;
    logic        s_axis_fir_tvalid;
    logic        s_set_coeffs;
    logic        busy;
    logic        underrun;

    always #5 clk = ~clk;

    fir_stream_driver #(
        .TAP_SIZE(3), .NBR_OF_TAPS(N), .X_N_SIZE(8),
        .SAMPLE_PERIOD(P), .STARTUP_CYCLES(SC), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .stream_en(stream_en), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .cfg_coeffs(cfg_coeffs),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .x_n(x_n),
        .s_axis_fir_tvalid(s_axis_fir_tvalid), .s_set_coeffs(s_set_coeffs),
        .busy(busy), .underrun(underrun)
    );

    // One entry per clock edge: inputs applied before the edge, outputs expected after it.
    typedef struct {
        logic        rst, sen, sv, cv;
        logic [7:0]  sd;
        logic [17:0] cc;
        logic [7:0]  x;
        logic        tv, set, srdy, crdy, bsy, und;
    } vec_t;

    vec_t sched[$];
    vec_t cur;
    int   n_cmp = 0;
    int   n_err = 0;
    int   load1_start, st1_start, st1_end;

    int cA[6] = '{0, -4, 3, 2, -1, 1};
    int cB[6] = '{3, -4, -1, 2, 1, -2};
    int cC[6] = '{-1, -1, 0, 3, -4, 2};
    int cD[6] = '{1, 2, 3, -4, -3, -2};
    int cE[6] = '{-4, 3, -2, 1, 0, -1};

    function automatic logic [17:0] pack(input int c[6]);
        logic [17:0] p;
        p = '0;
        for (int k = 0; k < 6; k++) p[k*3 +: 3] = 3'(c[k]);
        return p;
    endfunction

    task automatic push(input logic [7:0] x, input logic tv, input logic set, input logic srdy,
                        input logic crdy, input logic bsy, input logic und);
        vec_t e;
        e = cur;
        e.x = x; e.tv = tv; e.set = set; e.srdy = srdy; e.crdy = crdy; e.bsy = bsy; e.und = und;
        sched.push_back(e);
    endtask

    task automatic ph_reset(input int n);
        cur.rst = 1'b1; cur.sen = 1'b0; cur.sv = 1'b0; cur.cv = 1'b0;
        repeat (n) push(8'h00, 0, 0, 0, 0, 1, 0);
        cur.rst = 1'b0;
        repeat (SC - 1) push(8'h00, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic ph_idle(input int n);
        repeat (n) push(8'h00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ph_drain();
        repeat (D) push(8'h00, 0, 0, 0, 0, 1, 0);
    endtask

    // Load index j: j=0 repeats c[N-1], j=1..N-1 gives c[N-j] with set high, j=N gives c[0] with set low.
    task automatic ph_load(input int c[6], input int last_j, input int recv_at);
        cur.cc = pack(c);
        cur.cv = 1'b1;
        push(8'(c[N-1]), 0, 1, 0, 1, 1, 0);
        cur.cv = 1'b0;
        cur.cc = 18'h2AAAA;
        for (int j = 1; j <= last_j; j++) begin
            if (j == recv_at) cur.cv = 1'b1;
            push(8'(c[N-j]), 0, (j != N), 0, 0, 1, 0);
        end
    endtask

    task automatic ph_period(input int val, input logic valid, input int drop_at, input int cfg_at);
        logic [7:0] hold;
        cur.sv = valid;
        cur.sd = 8'(val);
        hold   = valid ? 8'(val) : 8'h00;
        push(hold, 1, 0, valid, 0, 1, !valid);
        cur.sv = 1'b0;
        cur.sd = 8'h5A;
        for (int i = 1; i < P; i++) begin
            if (i == drop_at) cur.sen = 1'b0;
            if (i == cfg_at) cur.cv = 1'b1;
            push(hold, 1, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_cycle(input int k);
        logic [13:0] a, e;
        a = {x_n, s_axis_fir_tvalid, s_set_coeffs, s_ready, cfg_ready, busy, underrun};
        e = {sched[k].x, sched[k].tv, sched[k].set, sched[k].srdy, sched[k].crdy, sched[k].bsy, sched[k].und};
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL cycle %0d {x,tv,set,srdy,crdy,busy,und}: got %h %b%b%b%b%b%b expected %h %b%b%b%b%b%b",
                     k, a[13:6], a[5], a[4], a[3], a[2], a[1], a[0],
                     e[13:6], e[5], e[4], e[3], e[2], e[1], e[0]);
        end
    endtask

    logic [7:0] lit_x[7] = '{8'h01, 8'h01, 8'hFF, 8'h02, 8'h03, 8'hFC, 8'h00};
    logic [6:0] lit_s    = 7'b1111110;
    logic [7:0] cap_x[7];
    logic       cap_s[7];
    int         taps[6];
    int         sr_idx[$];
    int         und_cnt = 0;
    logic       prev_set = 1'b0;

    initial begin
        cur = '{default: '0};

        ph_reset(3);
        ph_idle(2);
        load1_start = sched.size();
        ph_load(cA, N, -1);
        ph_idle(2);

        cur.sen   = 1'b1;
        st1_start = sched.size();
        ph_period(10, 1, -1, -1);
        ph_period(-20, 1, -1, -1);
        ph_period(127, 1, -1, -1);
        ph_period(-128, 1, -1, -1);
        ph_period(0, 0, -1, -1);
        ph_period(33, 1, 3, -1);
        st1_end = sched.size();
        ph_idle(2);

        cur.sen = 1'b1;
        ph_period(7, 1, -1, 3);
        ph_drain();
        ph_load(cB, N, -1);
        ph_idle(1);
        ph_period(-1, 1, -1, -1);
        ph_period(99, 1, 1, -1);
        ph_idle(2);

        cur.sen = 1'b1;
        ph_load(cC, N, -1);
        ph_idle(1);
        ph_period(42, 1, 2, -1);
        ph_idle(2);

        cur.sen = 1'b0;
        ph_load(cD, N, 3);
        ph_idle(1);
        ph_load(cE, N, -1);
        ph_idle(2);

        ph_load(cB, 3, -1);
        ph_reset(2);
        ph_idle(4);

        for (int k = 0; k < sched.size(); k++) begin
            reset      = sched[k].rst;
            stream_en  = sched[k].sen;
            s_valid    = sched[k].sv;
            s_data     = sched[k].sd;
            cfg_valid  = sched[k].cv;
            cfg_coeffs = sched[k].cc;
            @(posedge clk);
            @(negedge clk);
            chk_cycle(k);

            if (prev_set) begin
                for (int t = 5; t > 0; t--) taps[t] = taps[t-1];
                taps[0] = int'($signed(x_n));
            end
            prev_set = s_set_coeffs;

            if (k >= load1_start && k < load1_start + 7) begin
                cap_x[k - load1_start] = x_n;
                cap_s[k - load1_start] = s_set_coeffs;
            end
            if (k == load1_start + 7) begin
                for (int t = 0; t < 6; t++) chk($sformatf("filter_tap%0d", t), 32'(taps[t]), 32'(cA[t]));
            end
            if (k >= st1_start && k < st1_end && s_ready === 1'b1) sr_idx.push_back(k);
            if (underrun === 1'b1) und_cnt++;
        end

        for (int i = 0; i < 7; i++) begin
            chk($sformatf("load_x_j%0d", i), 32'(cap_x[i]), 32'(lit_x[i]));
            chk($sformatf("load_set_j%0d", i), 32'(cap_s[i]), 32'(lit_s[6-i]));
        end
        chk("sready_count", 32'(sr_idx.size()), 32'd5);
        if (sr_idx.size() >= 5) begin
            chk("sready_gap1", 32'(sr_idx[1] - sr_idx[0]), 32'd8);
            chk("sready_gap2", 32'(sr_idx[2] - sr_idx[1]), 32'd8);
            chk("sready_gap3", 32'(sr_idx[3] - sr_idx[2]), 32'd8);
            chk("sready_gap_underrun", 32'(sr_idx[4] - sr_idx[3]), 32'd16);
        end
        chk("underrun_pulses", 32'(und_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
